// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer (start/data/parity/stop) driving an external serializer, with a data-phase watchdog
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int WDOG_SLACK = 2
) (
   input  logic                  clk,
   input  logic                  rest,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  ser_done,
   input  logic                  ser_data,
   output logic                  ser_en,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  ser_err
);
   localparam int LIMIT = DATA_WIDTH + WDOG_SLACK;
   localparam int CW = (LIMIT > 2) ? LIMIT - 1 : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          par_en_q, par_en_d, par_bit_q, par_bit_d, err_q, err_d;
   logic          accept;

   assign accept = (state_q == IDLE || state_q == STOP) && data_valid;

   // Next state, parity capture on acceptance, watchdog counting and abort flag
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      par_en_d  = accept ? par_en : par_en_q;
      par_bit_d = accept ? ^p_data ^ par_typ : par_bit_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE:   state_d = data_valid ? START : IDLE;
         START:  state_d = DATA;
         DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (ser_done) state_d = par_en_q ? PARITY : STOP;
            else if (cnt_q == CW'(LIMIT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         PARITY: state_d = STOP;
         STOP:   state_d = data_valid ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and flag registers; reset aborts any frame without raising ser_err
   always_ff @(posedge clk) begin
      if (rest) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         err_q     <= err_d;
      end
   end

   assign busy    = state_q != IDLE;
   assign ser_en  = state_q == START || state_q == DATA;
   assign ser_err = err_q;
   assign tx_out  = state_q == START  ? 1'b0 :
                    state_q == DATA   ? ser_data :
                    state_q == PARITY ? par_bit_q : 1'b1;
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 Parameter WDOG_SLACK, default 2: extra DATA-state cycles tolerated beyond DATA_WIDTH before abort.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rest  in  1  reset, synchronous, active-high.
REQ-005 data_valid  in  1  request to transmit p_data.
REQ-006 p_data  in  DATA_WIDTH  parallel payload, sampled on acceptance.
REQ-007 par_en  in  1  1 = append parity bit.
REQ-008 par_typ  in  1  0 = even parity, 1 = odd parity.
REQ-009 ser_done  in  1  from serializer: last data bit is being presented.
REQ-010 ser_data  in  1  from serializer: current data bit, LSB first.
REQ-011 ser_en  out  1  enable to serializer (load, then shift).
REQ-012 tx_out  out  1  UART line; idle high.
REQ-013 busy  out  1  frame in progress.
REQ-014 ser_err  out  1  one-cycle pulse: serializer watchdog abort.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with one state per clock.
REQ-016 IDLE: tx_out=1, busy=0, ser_en=0; if data_valid=1, latch par_en, par_typ and par_bit, then go to START.
REQ-017 par_bit SHALL be the XOR-reduction of p_data, inverted when par_typ=1, computed at acceptance.
REQ-018 START: tx_out=0, busy=1, ser_en=1 (serializer load cycle); next state DATA unconditionally.
REQ-019 DATA: tx_out=ser_data, busy=1, ser_en=1; on ser_done=1 go to PARITY if latched par_en=1, else STOP.
REQ-020 PARITY: tx_out=latched par_bit, busy=1, ser_en=0; next state STOP.
REQ-021 STOP: tx_out=1, busy=1, ser_en=0; next state START if data_valid=1 (new data and parity latched), else IDLE.
REQ-022 data_valid SHALL be ignored in START, DATA and PARITY; inputs p_data, par_en and par_typ changing mid-frame SHALL NOT affect the current frame.
REQ-023 A DATA-cycle counter SHALL clear on entry to DATA and increment each DATA cycle; it is DATA_WIDTH+WDOG_SLACK-1 bits wide or wider, with no wrap before the limit.
REQ-024 If the counter reaches DATA_WIDTH+WDOG_SLACK with ser_done=0, the FSM SHALL go to IDLE and pulse ser_err for exactly one cycle.
REQ-025 ser_done=1 in any state other than DATA SHALL be ignored.
REQ-026 ser_en, busy and ser_err SHALL be decoded from registered state and flags only, so they are glitch-free relative to clk.
REQ-027 tx_out SHALL be a mux selected by the current state; ser_data passes through only in DATA.

Reset
REQ-028 When rest=1 on a rising edge, the block SHALL go to IDLE with tx_out=1, busy=0, ser_en=0, ser_err=0, with the counter and latched parity cleared.
REQ-029 Reset mid-frame SHALL abort the frame with no ser_err pulse; the line returns high the cycle after reset.
REQ-030 data_valid SHALL be ignored in any cycle where rest=1.

Verification
REQ-031 The bench SHALL include a serializer model that drives p_data bits LSB-first on ser_data for DATA_WIDTH DATA cycles, with ser_done=1 on the last cycle.
REQ-032 Even parity: p_data=0xA5, par_en=1, par_typ=0, data_valid pulse. Required: tx_out = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles); busy high for 11 cycles; then IDLE.
REQ-033 Odd parity: same stimulus with par_typ=1. Required: parity cycle tx_out=1; all other cycles identical to REQ-032.
REQ-034 No parity: p_data=0x0F, par_en=0. Required: tx_out = 0,1,1,1,1,0,0,0,0,1 (10 cycles); ser_en high for 9 cycles.
REQ-035 Back-to-back: data_valid held high, p_data=0x00 then 0xFF. Required: STOP goes directly to START with no idle cycle; the second frame's parity (even) = 0.
REQ-036 Watchdog: ser_done is never asserted. Required: after 10 DATA cycles, ser_err=1 for 1 cycle, tx_out=1, busy=0.
REQ-037 Reset: rest=1 during the 4th DATA cycle. Required: next cycle tx_out=1, busy=0, ser_en=0, ser_err=0; a new data_valid is then accepted normally.
